des_key_stream: RTL



---
 rtl/des_pkg.sv | 60 ++++++
 rtl/des_key_round.sv | 43 ++++
 rtl/des_key_stream.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/des_pkg.sv
// DES key-schedule tables, shift schedule and shared types
// for the streaming round-key generator.
package des_pkg;

  typedef enum logic {
    ENC = 1'b0,
    DEC = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_e;

  // Bit numbers are 1-based from the MSB, as in FIPS 46-3.
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam logic [1:0] SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++)
      r[6'(55 - i)] = k[6'(64 - PC1[i])];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++)
      r[6'(47 - i)] = cd[6'(56 - PC2[i])];
    return r;
  endfunction

endpackage

// File: rtl/des_key_round.sv
// One key-schedule step: rotate C,D left or right by 0..2
// places and derive the 48-bit round key through PC-2.
module des_key_round
  import des_pkg::*;
(
  input  logic [27:0] c_i,
  input  logic [27:0] d_i,
  input  logic [1:0]  sh_i,
  input  mode_e       dir_i,
  output logic [27:0] c_o,
  output logic [27:0] d_o,
  output logic [47:0] key_o
);

  logic enc;

  always_comb begin
    enc = (dir_i == ENC);
    c_o = c_i;
    d_o = d_i;
    unique case (1'b1)
      enc && sh_i == 2'd1: begin
        c_o = {c_i[26:0], c_i[27]};
        d_o = {d_i[26:0], d_i[27]};
      end
      enc && sh_i == 2'd2: begin
        c_o = {c_i[25:0], c_i[27:26]};
        d_o = {d_i[25:0], d_i[27:26]};
      end
      !enc && sh_i == 2'd1: begin
        c_o = {c_i[0], c_i[27:1]};
        d_o = {d_i[0], d_i[27:1]};
      end
      !enc && sh_i == 2'd2: begin
        c_o = {c_i[1:0], c_i[27:2]};
        d_o = {d_i[1:0], d_i[27:2]};
      end
      default: ;
    endcase
    key_o = pc2({c_o, d_o});
  end

endmodule

// File: rtl/des_key_stream.sv
// Sequential DES / 3DES-EDE key schedule streaming one
// 48-bit round key per valid/ready handshake.
module des_key_stream
  import des_pkg::*;
#(
  parameter int NUM_KEYS     = 1,
  parameter bit PARITY_CHECK = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic [64*NUM_KEYS-1:0] KEY,
  output logic                  busy,
  output logic                  rk_valid,
  input  logic                  rk_ready,
  output logic [47:0]           r_key,
  output logic [3:0]            rk_round,
  output logic [1:0]            rk_stage,
  output logic                  rk_last,
  output logic                  parity_err
);

  if (NUM_KEYS != 1 && NUM_KEYS != 3) begin : g_bad_keys
    $error("des_key_stream: NUM_KEYS must be 1 or 3");
  end

  localparam logic [1:0] LAST_S = 2'(NUM_KEYS - 1);

  state_e                state_q, state_d;
  logic [64*NUM_KEYS-1:0] key_q, key_d;
  mode_e                 mode_q, mode_d;
  mode_e                 dir_q, dir_d;
  logic [1:0]            stage_q, stage_d;
  logic [3:0]            round_q, round_d;
  logic [27:0]           c_q, c_d, d_q, d_d;
  logic                  busy_q, busy_d;
  logic                  valid_q, valid_d;
  logic [47:0]           rkey_q, rkey_d;
  logic                  last_q, last_d;
  logic                  perr_q, perr_d;

  logic                  par_err;
  logic [1:0]            kidx;
  logic [63:0]           stage_key;
  logic [55:0]           cd0;
  mode_e                 sdir;
  logic [27:0]           c_in, d_in, c_nx, d_nx;
  logic [1:0]            sh_in;
  mode_e                 dir_in;
  logic [47:0]           key_nx;
  logic                  hs;

  if (PARITY_CHECK) begin : g_par
    always_comb begin
      par_err = 1'b0;
      for (int b = 0; b < 8 * NUM_KEYS; b++)
        par_err = par_err | ~(^KEY[8*b +: 8]);
    end
  end else begin : g_no_par
    assign par_err = 1'b0;
  end

  // Decrypt runs the key stages back to front, with directions flipped.
  always_comb begin
    kidx = (mode_q == DEC) ? LAST_S - stage_q : stage_q;
    stage_key = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      if (kidx == 2'(i)) stage_key = key_q[64*i +: 64];
    sdir = mode_e'(mode_q ^ stage_q[0]);
    cd0 = pc1(stage_key);
  end

  always_comb begin
    if (state_q == LOAD) begin
      c_in   = cd0[55:28];
      d_in   = cd0[27:0];
      dir_in = sdir;
      sh_in  = (sdir == DEC) ? 2'd0 : SHIFT[0];
    end else begin
      c_in   = c_q;
      d_in   = d_q;
      dir_in = dir_q;
      sh_in  = (dir_q == DEC) ? SHIFT[4'd15 - round_q]
                              : SHIFT[round_q + 4'd1];
    end
  end

  des_key_round u_round (
    .c_i  (c_in),
    .d_i  (d_in),
    .sh_i (sh_in),
    .dir_i(dir_in),
    .c_o  (c_nx),
    .d_o  (d_nx),
    .key_o(key_nx)
  );

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    stage_d = stage_q;
    round_d = round_q;
    c_d     = c_q;
    d_d     = d_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    rkey_d  = rkey_q;
    last_d  = last_q;
    perr_d  = perr_q;
    hs      = valid_q && rk_ready;
    unique case (state_q)
      IDLE: if (start) begin
        key_d   = KEY;
        mode_d  = mode_e'(mode);
        perr_d  = par_err;
        busy_d  = 1'b1;
        stage_d = 2'd0;
        state_d = LOAD;
      end
      LOAD: begin
        c_d     = c_nx;
        d_d     = d_nx;
        rkey_d  = key_nx;
        dir_d   = sdir;
        round_d = 4'd0;
        valid_d = 1'b1;
        last_d  = 1'b0;
        state_d = RUN;
      end
      RUN: if (hs) begin
        if (round_q == 4'd15) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (stage_q == LAST_S) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            stage_d = stage_q + 2'd1;
            state_d = LOAD;
          end
        end else begin
          c_d     = c_nx;
          d_d     = d_nx;
          rkey_d  = key_nx;
          round_d = round_q + 4'd1;
          last_d  = (round_q == 4'd14) && (stage_q == LAST_S);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      mode_q  <= ENC;
      dir_q   <= ENC;
      stage_q <= '0;
      round_q <= '0;
      c_q     <= '0;
      d_q     <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      rkey_q  <= '0;
      last_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      stage_q <= stage_d;
      round_q <= round_d;
      c_q     <= c_d;
      d_q     <= d_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      rkey_q  <= rkey_d;
      last_q  <= last_d;
      perr_q  <= perr_d;
    end
  end

  assign busy       = busy_q;
  assign rk_valid   = valid_q;
  assign r_key      = rkey_q;
  assign rk_round   = round_q;
  assign rk_stage   = stage_q;
  assign rk_last    = last_q;
  assign parity_err = perr_q;

endmodule
